// File: rtl/sprite_line_renderer.sv
// Sprite line renderer. While one line is displayed from the front bank, the
// next line is prepared in the back bank: the sprite table is scanned for
// sprites crossing line_y, then their tile rows are fetched. line_start swaps
// the banks and starts the next preparation.

module sprite_slot_pixel #(
  parameter int TILE_W = 8
) (
  input  logic              vld,
  input  logic [7:0]        x,
  input  logic [TILE_W-1:0] hi,
  input  logic [TILE_W-1:0] lo,
  input  logic [7:0]        pix_x,
  output logic [1:0]        code
);
  logic [8:0]        off;
  logic              cov;
  logic [TILE_W-1:0] hs, ls;

  // One slot's colour code at pix_x; 00 when the slot does not cover it.
  // Shifting left by the offset brings the addressed pixel to the MSB.
  always_comb begin
    off  = {1'b0, pix_x} - {1'b0, x};
    cov  = vld && !off[8] && (off < 9'(TILE_W));
    hs   = hi << off[7:0];
    ls   = lo << off[7:0];
    code = cov ? {hs[TILE_W-1], ls[TILE_W-1]} : 2'b00;
  end
endmodule

module sprite_line_renderer #(
  parameter int SPRITE_NUM = 64,
  parameter int LINE_SLOTS = 8,
  parameter int TILE_W     = 8,
  parameter int TILE_H     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            line_start,
  input  logic [7:0]                      line_y,
  output logic [$clog2(SPRITE_NUM)-1:0]   spr_addr,
  input  logic [31:0]                     spr_data,
  output logic [8+$clog2(TILE_H)-1:0]     tile_addr,
  input  logic [2*TILE_W-1:0]             tile_data,
  input  logic [7:0]                      pix_x,
  output logic                            pix_hit,
  output logic [1:0]                      pix_pal,
  output logic [1:0]                      pix_code,
  output logic                            line_ready,
  output logic                            overflow,
  output logic                            late
);
  localparam int AW = $clog2(SPRITE_NUM);
  localparam int RW = $clog2(TILE_H);
  localparam int SW = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int NW = SW + 1;   // slot count 0..LINE_SLOTS
  localparam int CW = AW + 1;   // scan count 0..SPRITE_NUM

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

  // sprite found during SCAN, waiting for its tile row
  typedef struct packed {
    logic [7:0]    x;
    logic [1:0]    pal;
    logic [7:0]    tile;
    logic [RW-1:0] row;
    logic          hflip;
  } hit_t;

  // fully fetched display slot
  typedef struct packed {
    logic              vld;
    logic [7:0]        x;
    logic [1:0]        pal;
    logic [TILE_W-1:0] hi;
    logic [TILE_W-1:0] lo;
  } slot_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nhit, nhit_nxt, fcnt, cap;
  logic [SW-1:0] fidx, cidx;
  logic [7:0]    ly;
  logic          front;
  hit_t          hits [LINE_SLOTS];
  slot_t         bank [2][LINE_SLOTS];

  logic [8:0]        dy;
  logic              s_hit, s_room;
  logic [RW-1:0]     s_row;
  logic [TILE_W-1:0] cap_hi, cap_lo;
  logic              unused_bits;

  function automatic logic [TILE_W-1:0] rev(input logic [TILE_W-1:0] v);
    for (int i = 0; i < TILE_W; i++) rev[i] = v[TILE_W-1-i];
  endfunction

  // Evaluate the sprite entry returned for the address issued last cycle.
  always_comb begin
    dy       = {1'b0, ly} - {1'b0, spr_data[23:16]};
    s_hit    = (state == SCAN) && (cnt != '0) && !dy[8] && (dy < 9'(TILE_H));
    s_row    = spr_data[6] ? ~dy[RW-1:0] : dy[RW-1:0];
    s_room   = (nhit < NW'(LINE_SLOTS));
    nhit_nxt = nhit + NW'(s_hit && s_room);
  end

  // Memory addresses and the tile row being captured this cycle.
  always_comb begin
    cap       = fcnt - NW'(1);
    fidx      = fcnt[SW-1:0];
    cidx      = cap[SW-1:0];
    spr_addr  = (state == SCAN) ? cnt[AW-1:0] : '0;
    tile_addr = (state == FETCH && fcnt != nhit) ? {hits[fidx].tile, hits[fidx].row} : '0;
    cap_hi    = hits[cidx].hflip ? rev(tile_data[2*TILE_W-1:TILE_W]) : tile_data[2*TILE_W-1:TILE_W];
    cap_lo    = hits[cidx].hflip ? rev(tile_data[TILE_W-1:0]) : tile_data[TILE_W-1:0];
  end

  assign unused_bits = ^{spr_data[3:0], cap[NW-1:SW]};
  assign line_ready  = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next state: line_start always restarts the scan.
  always_comb begin
    nstate = state;
    if (line_start) nstate = SCAN;
    else begin
      case (state)
        SCAN:    if (cnt == CW'(SPRITE_NUM)) nstate = (nhit_nxt == '0) ? DONE : FETCH;
        FETCH:   if (fcnt == nhit) nstate = DONE;
        default: ;
      endcase
    end
  end

  // Scan/fetch counters, hit list, bank swap and back-bank fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      nhit     <= '0;
      fcnt     <= '0;
      ly       <= '0;
      front    <= 1'b0;
      overflow <= 1'b0;
      late     <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < LINE_SLOTS; i++) bank[b][i].vld <= 1'b0;
    end else begin
      late <= line_start && (state != DONE);
      if (line_start) begin
        // old front becomes the back bank; slots unfetched at swap time
        // were cleared here one line earlier, so they show as invalid
        front <= ~front;
        for (int i = 0; i < LINE_SLOTS; i++) bank[front][i].vld <= 1'b0;
        overflow <= 1'b0;
        cnt      <= '0;
        nhit     <= '0;
        fcnt     <= '0;
        ly       <= line_y;
      end else if (state == SCAN) begin
        if (cnt != CW'(SPRITE_NUM)) cnt <= cnt + CW'(1);
        if (s_hit) begin
          if (s_room)
            hits[nhit[SW-1:0]] <= '{x: spr_data[31:24], pal: spr_data[5:4],
                                    tile: spr_data[15:8], row: s_row, hflip: spr_data[7]};
          else
            overflow <= 1'b1;
          nhit <= nhit_nxt;
        end
      end else if (state == FETCH) begin
        if (fcnt != '0)
          bank[~front][cidx] <= '{vld: 1'b1, x: hits[cidx].x, pal: hits[cidx].pal,
                                  hi: cap_hi, lo: cap_lo};
        if (fcnt != nhit) fcnt <= fcnt + NW'(1);
      end
    end
  end

  // Per-slot pixel lookup on the front bank.
  logic [LINE_SLOTS-1:0][1:0] slot_code;

  for (genvar g = 0; g < LINE_SLOTS; g++) begin : g_slot
    sprite_slot_pixel #(.TILE_W(TILE_W)) u_pix (
      .vld   (bank[front][g].vld),
      .x     (bank[front][g].x),
      .hi    (bank[front][g].hi),
      .lo    (bank[front][g].lo),
      .pix_x (pix_x),
      .code  (slot_code[g])
    );
  end

  logic       win;
  logic [1:0] win_pal, win_code;

  // Lowest-numbered opaque slot wins; scan downward so it overrides.
  always_comb begin
    win      = 1'b0;
    win_pal  = 2'b00;
    win_code = 2'b00;
    for (int i = LINE_SLOTS - 1; i >= 0; i--) begin
      if (slot_code[i] != 2'b00) begin
        win      = 1'b1;
        win_pal  = bank[front][i].pal;
        win_code = slot_code[i];
      end
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_hit  <= 1'b0;
      pix_pal  <= 2'b00;
      pix_code <= 2'b00;
    end else begin
      pix_hit  <= win;
      pix_pal  <= win_pal;
      pix_code <= win_code;
    end
  end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer with behavioural sprite/tile ROMs.
module tb_sprite_line_renderer;
  logic        clk = 1'b0;
  logic        rst, line_start;
  logic [7:0]  line_y, pix_x;
  logic [5:0]  spr_addr;
  logic [31:0] spr_data;
  logic [10:0] tile_addr;
  logic [15:0] tile_data;
  logic        pix_hit, line_ready, overflow, late;
  logic [1:0]  pix_pal, pix_code;

  logic [31:0] spr_mem  [64];
  logic [15:0] tile_mem [2048];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  // 1-cycle latency ROMs
  always @(posedge clk) begin
    spr_data  <= spr_mem[spr_addr];
    tile_data <= tile_mem[tile_addr];
  end

  sprite_line_renderer dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y),
    .spr_addr(spr_addr), .spr_data(spr_data), .tile_addr(tile_addr),
    .tile_data(tile_data), .pix_x(pix_x), .pix_hit(pix_hit), .pix_pal(pix_pal),
    .pix_code(pix_code), .line_ready(line_ready), .overflow(overflow), .late(late)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] spr(input logic [7:0] x, input logic [7:0] y,
                                      input logic [7:0] tile, input logic hf,
                                      input logic vf, input logic [1:0] pal);
    return {x, y, tile, hf, vf, pal, 4'h0};
  endfunction

  task automatic clear_tbl;
    for (int i = 0; i < 64; i++) spr_mem[i] = spr(8'd0, 8'hFF, 8'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic start_line(input logic [7:0] y);
    line_y = y;
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
  endtask

  // cycles until line_ready, number of tile fetches, first tile address
  task automatic wait_ready(output int cyc, output int nf, output logic [10:0] ta);
    cyc = 0; nf = 0; ta = '0;
    while (!line_ready && cyc < 300) begin
      tick;
      cyc++;
      if (tile_addr != '0) begin
        if (nf == 0) ta = tile_addr;
        nf++;
      end
    end
    chk("ready_timeout", {31'd0, line_ready}, 32'd1);
  endtask

  task automatic probe(input string tag, input logic [7:0] x, input logic hit,
                       input logic [1:0] pal, input logic [1:0] code);
    pix_x = x;
    tick;
    chk({tag, "_hit"},  {31'd0, pix_hit},  {31'd0, hit});
    chk({tag, "_pal"},  {30'd0, pix_pal},  {30'd0, pal});
    chk({tag, "_code"}, {30'd0, pix_code}, {30'd0, code});
  endtask

  initial begin
    int cyc, nf;
    logic [10:0] ta;
    rst = 1'b1; line_start = 1'b0; line_y = '0; pix_x = '0;
    for (int i = 0; i < 2048; i++) tile_mem[i] = '0;
    clear_tbl();
    tick; tick;
    chk("rst_hit",   {31'd0, pix_hit}, 0);
    chk("rst_pal",   {30'd0, pix_pal}, 0);
    chk("rst_code",  {30'd0, pix_code}, 0);
    chk("rst_ready", {31'd0, line_ready}, 0);
    chk("rst_ovf",   {31'd0, overflow}, 0);
    chk("rst_late",  {31'd0, late}, 0);
    chk("rst_spra",  {26'd0, spr_addr}, 0);
    chk("rst_tila",  {21'd0, tile_addr}, 0);
    rst = 1'b0;
    tick; tick;
    chk("idle_ready", {31'd0, line_ready}, 0);
    chk("idle_spra",  {26'd0, spr_addr}, 0);

    // basic hit
    spr_mem[0] = spr(8'd10, 8'd20, 8'd3, 1'b0, 1'b0, 2'd2);
    tile_mem[{8'd3, 3'd2}] = 16'h0080;
    start_line(8'd22);
    wait_ready(cyc, nf, ta);
    chk("basic_fetch_len", cyc - 65, 2);
    chk("basic_tile_addr", {21'd0, ta}, {21'd0, 8'd3, 3'd2});
    start_line(8'd22);
    chk("basic_late", {31'd0, late}, 0);
    chk("basic_ovf",  {31'd0, overflow}, 0);
    probe("basic_x10", 8'd10, 1'b1, 2'd2, 2'b01);
    probe("basic_x11", 8'd11, 1'b0, 2'd0, 2'b00);
    probe("basic_x9",  8'd9,  1'b0, 2'd0, 2'b00);
    wait_ready(cyc, nf, ta);

    // hflip + vflip
    spr_mem[0] = spr(8'd10, 8'd20, 8'd3, 1'b1, 1'b1, 2'd2);
    tile_mem[{8'd3, 3'd2}] = 16'h4000;
    tile_mem[{8'd3, 3'd5}] = 16'h0080;
    start_line(8'd22);
    wait_ready(cyc, nf, ta);
    chk("flip_tile_addr", {21'd0, ta}, {21'd0, 8'd3, 3'd5});
    start_line(8'd22);
    probe("flip_x17", 8'd17, 1'b1, 2'd2, 2'b01);
    probe("flip_x10", 8'd10, 1'b0, 2'd0, 2'b00);
    probe("flip_x16", 8'd16, 1'b0, 2'd0, 2'b00);
    wait_ready(cyc, nf, ta);

    // overflow: 10 sprites on line 40
    clear_tbl();
    for (int i = 0; i < 10; i++) begin
      spr_mem[i] = spr(8'(i * 10 + 5), 8'd40, 8'(10 + i), 1'b0, 1'b0, 2'(i % 4));
      tile_mem[{8'(10 + i), 3'd0}] = 16'h00FF;
    end
    start_line(8'd40);
    wait_ready(cyc, nf, ta);
    chk("ovf_set",       {31'd0, overflow}, 1);
    chk("ovf_fetch_len", cyc - 65, 9);
    chk("ovf_fetches",   nf, 8);
    chk("ovf_first_ta",  {21'd0, ta}, {21'd0, 8'd10, 3'd0});
    start_line(8'd40);
    chk("ovf_clear", {31'd0, overflow}, 0);
    probe("ovf_spr0", 8'd5,  1'b1, 2'd0, 2'b01);
    probe("ovf_spr7", 8'd75, 1'b1, 2'd3, 2'b01);
    probe("ovf_spr8", 8'd85, 1'b0, 2'd0, 2'b00);
    wait_ready(cyc, nf, ta);

    // priority and transparency
    clear_tbl();
    spr_mem[2] = spr(8'd50, 8'd60, 8'd20, 1'b0, 1'b0, 2'd1);
    spr_mem[5] = spr(8'd50, 8'd60, 8'd21, 1'b0, 1'b0, 2'd3);
    tile_mem[{8'd20, 3'd0}] = 16'h0F0F;
    tile_mem[{8'd21, 3'd0}] = 16'hFF00;
    start_line(8'd60);
    wait_ready(cyc, nf, ta);
    chk("prio_fetch_len", cyc - 65, 3);
    start_line(8'd60);
    probe("prio_x50", 8'd50, 1'b1, 2'd3, 2'b10);
    probe("prio_x54", 8'd54, 1'b1, 2'd1, 2'b11);
    probe("prio_x58", 8'd58, 1'b0, 2'd0, 2'b00);
    wait_ready(cyc, nf, ta);

    // late line_start 30 cycles after the previous one
    start_line(8'd60);
    chk("late_normal", {31'd0, late}, 0);
    repeat (29) tick;
    start_line(8'd60);
    chk("late_pulse", {31'd0, late}, 1);
    probe("late_x50", 8'd50, 1'b0, 2'd0, 2'b00);
    chk("late_single", {31'd0, late}, 0);
    probe("late_x54", 8'd54, 1'b0, 2'd0, 2'b00);
    wait_ready(cyc, nf, ta);

    // reset in the middle of FETCH
    start_line(8'd60);
    probe("pre_rst_x50", 8'd50, 1'b1, 2'd3, 2'b10);
    repeat (64) tick;
    chk("midfetch_ta", {21'd0, tile_addr}, {21'd0, 8'd20, 3'd0});
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_hit",   {31'd0, pix_hit}, 0);
    chk("mrst_pal",   {30'd0, pix_pal}, 0);
    chk("mrst_code",  {30'd0, pix_code}, 0);
    chk("mrst_ready", {31'd0, line_ready}, 0);
    chk("mrst_ovf",   {31'd0, overflow}, 0);
    chk("mrst_late",  {31'd0, late}, 0);
    chk("mrst_spra",  {26'd0, spr_addr}, 0);
    chk("mrst_tila",  {21'd0, tile_addr}, 0);
    tick; tick;
    chk("post_rst_hit",   {31'd0, pix_hit}, 0);
    chk("post_rst_ready", {31'd0, line_ready}, 0);
    start_line(8'd60);
    probe("post_rst_x50", 8'd50, 1'b0, 2'd0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
